// File: rtl/aer_spike_decoder.sv
// AER receiver: synchronises an asynchronous 4-phase request, queues valid addresses
// in a small FIFO and replays them as one-hot, one-cycle spike pulses.
module aer_spike_decoder #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          aer_req,
    input  logic [ADDR_W-1:0]             aer_addr,
    output logic                          aer_ack,
    input  logic                          enable,
    output logic [NUM_CH-1:0]             spike_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   event_total,
    output logic                          err_addr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_ARM  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    if (NUM_CH > (2 ** ADDR_W)) begin : g_bad_num_ch
        $error("NUM_CH exceeds the address space");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic              req_meta;
    logic              req_s;
    logic [1:0]        sync_vld;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              capture;
    logic              addr_ok;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] mem [FIFO_DEPTH];
    logic [NUM_CH-1:0] spike_next;

    // sync_vld marks when req_s reflects aer_req again after reset, so a request
    // still high from before reset is seen by ARM instead of the cleared flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            req_meta <= 1'b0;
            req_s    <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            req_meta <= aer_req;
            req_s    <= req_meta;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign addr_ok    = (int'(aer_addr) < NUM_CH);

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_ARM: begin
                if (sync_vld[1] && !req_s) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_s && !fifo_full) begin
                    capture    = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) state_next = ST_IDLE;
            end
            default: state_next = ST_ARM;
        endcase
    end

    assign push = capture && addr_ok;
    assign pop  = enable && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_ARM;
            aer_ack <= 1'b0;
        end else begin
            state   <= state_next;
            aer_ack <= (state_next == ST_ACK);
        end
    end

    // NOTE: storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= aer_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        spike_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pop && (int'(mem[rd_ptr]) == i)) spike_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_out   <= '0;
            event_total <= '0;
            err_addr    <= 1'b0;
        end else begin
            spike_out <= spike_next;
            if (push) event_total <= event_total + 16'd1;
            if (capture && !addr_ok) err_addr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aer_spike_decoder.sv
// Directed bench for aer_spike_decoder: a default instance plus a NUM_CH=3 instance
// for out-of-range addresses.
module tb_aer_spike_decoder;

    logic        clk;
    logic        rst_n;
    logic        aer_req;
    logic [1:0]  aer_addr;
    logic        aer_ack;
    logic        enable;
    logic [3:0]  spike_out;
    logic [3:0]  fifo_count;
    logic [15:0] event_total;
    logic        err_addr;

    logic        b_req;
    logic [1:0]  b_addr;
    logic        b_ack;
    logic        b_en;
    logic [2:0]  b_spike;
    logic [3:0]  b_count;
    logic [15:0] b_total;
    logic        b_err;

    int n_checks = 0;
    int n_err    = 0;
    logic [3:0] spk_acc;
    logic [2:0] spk3_acc;
    logic [3:0] exp_seq [9];

    aer_spike_decoder dut (
        .clk(clk), .rst_n(rst_n), .aer_req(aer_req), .aer_addr(aer_addr),
        .aer_ack(aer_ack), .enable(enable), .spike_out(spike_out),
        .fifo_count(fifo_count), .event_total(event_total), .err_addr(err_addr)
    );

    aer_spike_decoder #(.NUM_CH(3), .ADDR_W(2), .FIFO_DEPTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .aer_req(b_req), .aer_addr(b_addr),
        .aer_ack(b_ack), .enable(b_en), .spike_out(b_spike),
        .fifo_count(b_count), .event_total(b_total), .err_addr(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            spk_acc  = spk_acc | spike_out;
            spk3_acc = spk3_acc | b_spike;
        end
    endtask

    // which: 0 = default instance, 1 = NUM_CH=3 instance
    task automatic wait_ack(input int which, input logic val, input string tag);
        int n = 0;
        while (((which == 0) ? aer_ack : b_ack) !== val && n < 20) begin
            tick(1);
            n++;
        end
        check(tag, (which == 0) ? aer_ack : b_ack, val);
    endtask

    task automatic hs(input logic [1:0] a);
        aer_addr = a;
        aer_req  = 1'b1;
        wait_ack(0, 1'b1, "hs_ack");
        aer_req  = 1'b0;
        wait_ack(0, 1'b0, "hs_release");
    endtask

    initial begin
        rst_n = 1'b0; aer_req = 1'b0; aer_addr = '0; enable = 1'b0;
        b_req = 1'b0; b_addr = '0; b_en = 1'b0;
        spk_acc = '0; spk3_acc = '0;
        tick(3);
        check("rst_ack", aer_ack, 0);
        check("rst_spike", spike_out, 0);
        check("rst_count", fifo_count, 0);
        check("rst_total", event_total, 0);
        check("rst_err", err_addr, 0);
        check("rst_b_ack", b_ack, 0);
        rst_n = 1'b1;
        tick(4);

        // single event, latency and one-cycle pulse
        enable = 1'b1; aer_addr = 2'd2; aer_req = 1'b1;
        tick(1); check("lat_edge0_ack", aer_ack, 0);
        tick(1); check("lat_edge1_ack", aer_ack, 0);
        tick(1); check("lat_edge2_ack", aer_ack, 1);
        check("lat_edge2_count", fifo_count, 1);
        check("lat_edge2_spike", spike_out, 0);
        tick(1); check("lat_edge3_spike", spike_out, 4'b0100);
        check("lat_edge3_count", fifo_count, 0);
        check("single_total", event_total, 1);
        aer_req = 1'b0;
        tick(1); check("single_pulse_end", spike_out, 0);
        wait_ack(0, 1'b0, "single_release");

        // out-of-range address on the 3-channel instance
        b_en = 1'b1; b_addr = 2'd3; b_req = 1'b1; spk3_acc = '0;
        wait_ack(1, 1'b1, "inv_ack");
        check("inv_err", b_err, 1);
        b_req = 1'b0;
        wait_ack(1, 1'b0, "inv_release");
        tick(2);
        check("inv_no_spike", spk3_acc, 0);
        check("inv_count", b_count, 0);
        check("inv_total", b_total, 0);
        b_addr = 2'd2; b_req = 1'b1;
        wait_ack(1, 1'b1, "b_valid_ack");
        tick(1); check("b_valid_spike", b_spike, 3'b100);
        b_req = 1'b0;
        wait_ack(1, 1'b0, "b_valid_release");
        check("b_valid_total", b_total, 1);
        check("b_err_sticky", b_err, 1);

        // burst into a stalled FIFO, backpressure, then drain in order
        enable = 1'b0;
        for (int i = 0; i < 8; i++) hs(2'(i % 4));
        check("burst_count", fifo_count, 8);
        check("burst_total", event_total, 9);
        aer_addr = 2'd2; aer_req = 1'b1;
        tick(10);
        check("full_no_ack", aer_ack, 0);
        check("full_count", fifo_count, 8);
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
        enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick(1);
            check($sformatf("drain_%0d", k), spike_out, exp_seq[k]);
            if (k == 1) begin
                check("ninth_ack", aer_ack, 1);
                check("ninth_push_pop_count", fifo_count, 7);
            end
        end
        check("drain_count", fifo_count, 0);
        aer_req = 1'b0;
        tick(1); check("drain_end", spike_out, 0);
        wait_ack(0, 1'b0, "ninth_release");
        check("drain_total", event_total, 10);

        // push and pop on the same edge at occupancy 4
        enable = 1'b0;
        hs(2'd3); hs(2'd2); hs(2'd1); hs(2'd0);
        aer_addr = 2'd1; aer_req = 1'b1;
        tick(2);
        check("sim_pre_count", fifo_count, 4);
        enable = 1'b1;
        tick(1);
        check("sim_count_held", fifo_count, 4);
        check("sim_ack", aer_ack, 1);
        check("sim_spike0", spike_out, 4'b1000);
        exp_seq[0] = 4'b0100; exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("sim_order_%0d", k), spike_out, exp_seq[k]);
        end
        check("sim_drained", fifo_count, 0);
        aer_req = 1'b0;
        wait_ack(0, 1'b0, "sim_release");
        check("sim_total", event_total, 15);

        // counter wrap from 0xFFFF
        force dut.event_total = 16'hFFFF;
        tick(1);
        release dut.event_total;
        tick(1);
        check("wrap_preload", event_total, 16'hFFFF);
        hs(2'd0);
        check("wrap_zero", event_total, 0);

        // reset while acknowledging, request held high across it
        aer_addr = 2'd3; aer_req = 1'b1;
        wait_ack(0, 1'b1, "rstack_ack");
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("rstack_ack_low", aer_ack, 0);
        check("rstack_count", fifo_count, 0);
        check("rstack_total", event_total, 0);
        check("rstack_b_err_cleared", b_err, 0);
        spk_acc = '0;
        tick(12);
        check("rstack_no_ack", aer_ack, 0);
        check("rstack_no_spike", spk_acc, 0);
        check("rstack_no_event", event_total, 0);
        aer_req = 1'b0;
        tick(4);
        aer_addr = 2'd1; aer_req = 1'b1;
        wait_ack(0, 1'b1, "post_rst_ack");
        tick(1); check("post_rst_spike", spike_out, 4'b0010);
        aer_req = 1'b0;
        tick(1); check("post_rst_spike_end", spike_out, 0);
        wait_ack(0, 1'b0, "post_rst_release");
        check("post_rst_total", event_total, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/aer_spike_decoder.md
AER_SPIKE_DECODER -- requirements
Module: aer_spike_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of spike output channels.
REQ-002 SHALL have parameter ADDR_W, default 2, the address width; NUM_CH <= 2**ADDR_W.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, the event FIFO depth; power of two, >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port aer_req, input, 1 bit: AER request, asynchronous to clk.
REQ-007 SHALL have port aer_addr, input, ADDR_W bits: event address; the sender holds it stable while aer_req is high.
REQ-008 SHALL have port aer_ack, output, 1 bit: AER acknowledge, registered.
REQ-009 SHALL have port enable, input, 1 bit: when high, events are emitted from the FIFO.
REQ-010 SHALL have port spike_out, output, NUM_CH bits: one-cycle one-hot spike pulses, registered.
REQ-011 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-012 SHALL have port event_total, output, 16 bits: count of accepted valid events; wraps 0xFFFF -> 0.
REQ-013 SHALL have port err_addr, output, 1 bit: sticky flag, set when an address >= NUM_CH is received.

Function
REQ-014 SHALL pass aer_req through a 2-flop synchronizer; req_s is the second flop's output, and the FSM uses only req_s.
REQ-015 SHALL implement handshake FSM states ARM, IDLE, ACK.
- ARM: aer_ack=0; go to IDLE when req_s==0.
- IDLE: aer_ack=0; when req_s==1 and the FIFO is not full, capture aer_addr and go to ACK.
- ACK: aer_ack=1; when req_s==0, go to IDLE, which drives aer_ack=0.
REQ-016 SHALL, at the capturing edge of REQ-015, push the address into the FIFO when it is < NUM_CH, and increment event_total on the same edge.
REQ-017 SHALL, when the captured address is >= NUM_CH, not push, not count, set err_addr, and still complete the handshake.
REQ-018 SHALL apply backpressure when the FIFO is full:
- stay in IDLE with aer_ack=0;
- never drop an event;
- fullness is evaluated on pre-edge occupancy.
REQ-019 SHALL, on each edge where enable==1 and the FIFO is non-empty, pop one entry and register spike_out = one-hot(entry) for exactly one cycle; otherwise spike_out=0.
REQ-020 SHALL sustain one pop per cycle; back-to-back pops produce spike_out pulses on consecutive cycles.
REQ-021 SHALL handle a push and a pop on the same edge by leaving fifo_count unchanged and preserving FIFO order.
REQ-022 SHALL, when enable==0, continue to accept handshakes into the FIFO, halt pops, and hold spike_out at 0.
REQ-023 SHALL have the following latency from an idle, empty state, with aer_req first sampled high at edge N:
- req_s is high after edge N+1;
- the push occurs and aer_ack rises after edge N+2;
- spike_out pulses after edge N+3, if enable==1.
REQ-024 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Reset
REQ-025 SHALL, while rst_n==0 at an edge, set:
- state=ARM, aer_ack=0, spike_out=0;
- FIFO emptied, fifo_count=0;
- event_total=0, err_addr=0;
- synchronizer flops cleared.
REQ-026 SHALL, on reset asserted mid-handshake, drop aer_ack and treat a still-high aer_req as already consumed (ARM) rather than as a new event.
REQ-027 SHALL clear err_addr only by reset.

Verification
REQ-028 Single event: enable=1, 4-phase handshake with addr=2 -> aer_ack rises 3 edges after aer_req rises; spike_out=4'b0100 for exactly 1 cycle, 1 edge later; event_total=1.
REQ-029 Burst: enable=0, 8 handshakes with addr 0,1,2,3,0,1,2,3 -> fifo_count=8; a 9th req gets no aer_ack. Then enable=1 -> 8 consecutive pulses in order 1,2,4,8,1,2,4,8; the 9th is then acked and emitted; event_total=9.
REQ-030 Invalid address: NUM_CH=3, addr=3 -> handshake completes, err_addr=1, no spike, event_total unchanged, fifo_count=0.
REQ-031 Reset in ACK: aer_req held high, rst_n pulsed low for 1 cycle -> aer_ack=0, no new event while aer_req stays high; after aer_req drops and rises with addr=1, spike_out=4'b0010 once.
REQ-032 Simultaneous push and pop: FIFO at 4 entries, enable=1, a handshake push coincides with a pop -> fifo_count stays 4 on that edge; emission order is preserved.
REQ-033 Counter wrap: event_total preloaded via 65535 accepted events, plus one more -> event_total=0.
